// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order ID allocation, out-of-order writeback, in-order commit.
// Optional ROB_WB_FORWARD_EN shows a writeback in the available vector combinationally in the same cycle.
module reorder_buffer #(
  parameter int ID_SIZE          = 2,
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int REGISTER_SIZE    = 32,
  localparam int DEPTH = 1 << ID_SIZE,
  localparam int UW    = REG_ADDRESS_SIZE + ID_SIZE + 2,
  localparam int AW    = REGISTER_SIZE + REG_ADDRESS_SIZE + ID_SIZE + 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic [REG_ADDRESS_SIZE-1:0] alloc_addr,
  input  logic                        alloc_writes_reg,
  output logic [ID_SIZE-1:0]          alloc_id,
  input  logic                        wb_valid,
  input  logic [ID_SIZE-1:0]          wb_id,
  input  logic [REGISTER_SIZE-1:0]    wb_value,
  output logic                        commit_valid,
  output logic [REG_ADDRESS_SIZE-1:0] commit_addr,
  output logic                        commit_writes_reg,
  output logic [REGISTER_SIZE-1:0]    commit_value,
  output logic [ID_SIZE-1:0]          tail,
  output logic [DEPTH*UW-1:0]         unavailable,
  output logic [DEPTH*AW-1:0]         available
);

  logic                        valid_q  [DEPTH];
  logic                        ready_q  [DEPTH];
  logic                        writes_q [DEPTH];
  logic [REG_ADDRESS_SIZE-1:0] addr_q   [DEPTH];
  logic [REGISTER_SIZE-1:0]    value_q  [DEPTH];
  logic [ID_SIZE-1:0]          head_q, tail_q;
  logic [ID_SIZE:0]            count_q;

  logic do_alloc, do_wb;

  assign alloc_ready       = (count_q != (ID_SIZE+1)'(DEPTH));
  assign do_alloc          = alloc_valid && alloc_ready;
  assign do_wb             = wb_valid && valid_q[wb_id] && !ready_q[wb_id];
  assign commit_valid      = valid_q[head_q] && ready_q[head_q];
  assign commit_addr       = addr_q[head_q];
  assign commit_writes_reg = writes_q[head_q];
  assign commit_value      = value_q[head_q];
  assign alloc_id          = tail_q;
  assign tail              = tail_q;

  // Payload fields are cleared along with the valid bits so commit outputs read 0 after reset.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        ready_q[i]  <= 1'b0;
        writes_q[i] <= 1'b0;
        addr_q[i]   <= '0;
        value_q[i]  <= '0;
      end
    end else begin
      if (do_wb) begin
        ready_q[wb_id] <= 1'b1;
        value_q[wb_id] <= wb_value;
      end
      if (commit_valid) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + ID_SIZE'(1);
      end
      // Allocation and commit never target the same slot: that needs the buffer full or empty.
      if (do_alloc) begin
        valid_q[tail_q]  <= 1'b1;
        ready_q[tail_q]  <= 1'b0;
        writes_q[tail_q] <= alloc_writes_reg;
        addr_q[tail_q]   <= alloc_addr;
        tail_q           <= tail_q + ID_SIZE'(1);
      end
      case ({do_alloc, commit_valid})
        2'b10:   count_q <= count_q + (ID_SIZE+1)'(1);
        2'b01:   count_q <= count_q - (ID_SIZE+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_export
    localparam logic [ID_SIZE-1:0] SLOT_ID = ID_SIZE'(i);
    logic fwd_hit;
`ifdef ROB_WB_FORWARD_EN
    assign fwd_hit = wb_valid && (wb_id == SLOT_ID) && valid_q[i] && !ready_q[i];
`else
    assign fwd_hit = 1'b0;
`endif
    assign unavailable[i*UW +: UW] = {addr_q[i], writes_q[i], SLOT_ID,
                                      valid_q[i] && !ready_q[i] && !fwd_hit};
    assign available[i*AW +: AW]   = {fwd_hit ? wb_value : value_q[i], addr_q[i], writes_q[i],
                                      SLOT_ID, (valid_q[i] && ready_q[i]) || fwd_hit};
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: program-order queue model, directed plan, then random traffic.
module tb_reorder_buffer;
  localparam int UW = 9;
  localparam int AW = 41;

  logic        clk, reset, flush, alloc_valid, alloc_writes_reg, wb_valid;
  logic [4:0]  alloc_addr;
  logic [1:0]  wb_id;
  logic [31:0] wb_value;
  logic        alloc_ready, commit_valid, commit_writes_reg;
  logic [1:0]  alloc_id, tail;
  logic [4:0]  commit_addr;
  logic [31:0] commit_value;
  logic [4*UW-1:0] unavailable;
  logic [4*AW-1:0] available;

  reorder_buffer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
    .alloc_writes_reg(alloc_writes_reg), .alloc_id(alloc_id),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
    .commit_valid(commit_valid), .commit_addr(commit_addr),
    .commit_writes_reg(commit_writes_reg), .commit_value(commit_value),
    .tail(tail), .unavailable(unavailable), .available(available)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [4:0]  addr;
    bit          wr;
    bit          rdy;
    logic [31:0] val;
  } ent_t;

  ent_t model_q[$];
  ent_t exp_q[$];
  int   m_tail;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [UW-1:0] u;
    logic [AW-1:0] a;
    int k;
    bit f, rdy, fwd;
    chk("alloc_ready", alloc_ready, model_q.size() != 4);
    chk("tail", tail, m_tail);
    chk("alloc_id", alloc_id, m_tail);
    chk("commit_valid", commit_valid, model_q.size() > 0 && model_q[0].rdy);
    for (int i = 0; i < 4; i++) begin
      k = -1;
      foreach (model_q[j]) if (model_q[j].id == i) k = j;
      f   = (k >= 0);
      rdy = f && model_q[k].rdy;
      fwd = 1'b0;
`ifdef ROB_WB_FORWARD_EN
      fwd = wb_valid && (int'(wb_id) == i) && f && !rdy;
`endif
      u = unavailable[i*UW +: UW];
      a = available[i*AW +: AW];
      chk($sformatf("unavail_valid[%0d]", i), u[0], f && !rdy && !fwd);
      chk($sformatf("avail_valid[%0d]", i), a[0], f && (rdy || fwd));
      if (f && !rdy && !fwd) begin
        chk($sformatf("unavail_fields[%0d]", i), u[UW-1:1], {model_q[k].addr, model_q[k].wr, 2'(i)});
      end
      if (f && (rdy || fwd)) begin
        chk($sformatf("avail_fields[%0d]", i), a[UW-1:1], {model_q[k].addr, model_q[k].wr, 2'(i)});
        chk($sformatf("avail_value[%0d]", i), a[AW-1:UW], fwd ? wb_value : model_q[k].val);
      end
    end
  endtask

  // One clock cycle: drive at negedge, check registered and combinational outputs, then advance the model.
  task automatic cycle(input bit r, input bit f, input bit av, input logic [4:0] aa, input bit aw,
                       input bit wv, input logic [1:0] wi, input logic [31:0] wval);
    bit do_c, do_a;
    @(negedge clk);
    reset = r; flush = f; alloc_valid = av; alloc_addr = aa; alloc_writes_reg = aw;
    wb_valid = wv; wb_id = wi; wb_value = wval;
    #1;
    if (!r) check_outputs();
    @(posedge clk);
    if (r || f) begin
      model_q.delete();
      exp_q.delete();
      m_tail = 0;
    end else begin
      do_c = model_q.size() > 0 && model_q[0].rdy;
      do_a = av && model_q.size() != 4;
      if (wv) begin
        foreach (model_q[j]) if (model_q[j].id == int'(wi) && !model_q[j].rdy) begin
          model_q[j].rdy = 1'b1; model_q[j].val = wval;
        end
        foreach (exp_q[j]) if (exp_q[j].id == int'(wi) && !exp_q[j].rdy) begin
          exp_q[j].rdy = 1'b1; exp_q[j].val = wval;
        end
      end
      if (do_c) void'(model_q.pop_front());
      if (do_a) begin
        model_q.push_back('{m_tail, aa, aw, 1'b0, 32'h0});
        exp_q.push_back('{m_tail, aa, aw, 1'b0, 32'h0});
        m_tail = (m_tail + 1) % 4;
      end
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 5'd0, 0, 0, 2'd0, 32'h0);
  endtask

  // Commit monitor: every retirement must match the oldest expected instruction.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && !flush && commit_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL commit_unexpected: got commit of addr %0h expected none", commit_addr);
        end else begin
          e = exp_q.pop_front();
          chk("commit_head_ready", commit_valid, e.rdy);
          chk("commit_addr", commit_addr, e.addr);
          chk("commit_writes_reg", commit_writes_reg, e.wr);
          chk("commit_value", commit_value, e.val);
        end
      end
    end
  end

  initial begin
    reset = 1; flush = 0; alloc_valid = 0; alloc_addr = 0; alloc_writes_reg = 0;
    wb_valid = 0; wb_id = 0; wb_value = 0; m_tail = 0;
    cycle(1, 0, 0, 5'd0, 0, 0, 2'd0, 32'h0);
    cycle(1, 0, 0, 5'd0, 0, 0, 2'd0, 32'h0);
    @(negedge clk); #1;
    chk("reset_commit_addr", commit_addr, 0);
    chk("reset_commit_value", commit_value, 0);
    chk("reset_commit_writes", commit_writes_reg, 0);
    chk("reset_alloc_ready", alloc_ready, 1);

    for (int i = 1; i <= 4; i++) cycle(0, 0, 1, 5'(i), 1, 0, 2'd0, 32'h0);
    idle();
    chk("full_alloc_ready", alloc_ready, 0);
    cycle(0, 0, 0, 5'd0, 0, 1, 2'd2, 32'hDEAD);
    idle();
    cycle(0, 0, 0, 5'd0, 0, 1, 2'd0, 32'h1);
    // Full with ready head: allocation refused while ID 0 retires, then ID 0 is reissued.
    cycle(0, 0, 1, 5'd9, 1, 0, 2'd0, 32'h0);
    cycle(0, 0, 0, 5'd0, 0, 1, 2'd0, 32'h5555);
    cycle(0, 0, 1, 5'd10, 0, 0, 2'd0, 32'h0);
    cycle(0, 0, 0, 5'd0, 0, 1, 2'd2, 32'hBEEF);
    idle();
    cycle(0, 0, 0, 5'd0, 0, 1, 2'd1, 32'h11);
    idle();
    idle();
    cycle(0, 0, 1, 5'd12, 1, 0, 2'd0, 32'h0);
    idle();
    cycle(0, 1, 1, 5'd13, 1, 1, 2'd3, 32'h33);
    idle();
    chk("flush_tail", tail, 0);
    chk("flush_alloc_ready", alloc_ready, 1);
    cycle(0, 0, 1, 5'd20, 1, 0, 2'd0, 32'h0);
    cycle(0, 0, 1, 5'd21, 0, 0, 2'd0, 32'h0);
    cycle(0, 0, 0, 5'd0, 0, 1, 2'd1, 32'hF00D);
    idle();
    idle();

    for (int n = 0; n < 600; n++) begin
      cycle(n == 300, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 60,
            5'($urandom), 1'($urandom), $urandom_range(0, 99) < 50,
            2'($urandom), $urandom);
    end
    repeat (6) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
